mem_access_unit: RTL

Load/store initiator between the CPU execute stage and `data_memory`. It accepts one byte-addressed load or store request at a time over a valid/ready handshake and drives the word-wide, single-port memory port. Byte stores are performed as read-modify-write sequences. Each completed access returns a one-cycle response pulse. It is the requesting end of the `data_memory` interface, and its memory-side ports connect directly to that block.

---
 rtl/mem_access_unit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for a single-port, registered-read data memory.
// Define MAU_BYTE_EN to build byte loads and read-modify-write byte stores.
module mem_access_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                req_valid_in,
    output logic                req_ready_out,
    input  logic                req_write_in,
    input  logic                req_byte_in,
    input  logic [ADDR_W+1:0]   req_addr_in,
    input  logic [DATA_W-1:0]   req_wdata_in,
    output logic                rsp_valid_out,
    output logic [DATA_W-1:0]   rsp_rdata_out,
    output logic                mem_write_en_out,
    output logic [ADDR_W-1:0]   mem_addr_out,
    output logic [DATA_W-1:0]   mem_data_out,
    input  logic [DATA_W-1:0]   mem_data_in
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_RDW  = 3'd2;
    localparam logic [2:0] ST_WR   = 3'd3;
    localparam logic [2:0] ST_RESP = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              accept;

    assign accept = (state_q == ST_IDLE) && req_valid_in;

`ifdef MAU_BYTE_EN
    logic              write_q, write_d;
    logic              byte_q, byte_d;
    logic [1:0]        lane_q, lane_d;
    logic [7:0]        bdata_q, bdata_d;
    logic [DATA_W-1:0] merged_word;
    logic [DATA_W-1:0] lane_word;

    // Read-modify-write merge: only the addressed lane takes the store byte.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[gi*8 +: 8] = (lane_q == 2'(gi)) ? bdata_q : mem_data_in[gi*8 +: 8];
        end
    endgenerate

    assign lane_word = {{(DATA_W-8){1'b0}}, mem_data_in[{lane_q, 3'b000} +: 8]};
`else
    logic unused_byte_bits;
    assign unused_byte_bits = ^{req_byte_in, req_addr_in[1:0]};
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_data_d  = mem_data_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef MAU_BYTE_EN
        write_d     = write_q;
        byte_d      = byte_q;
        lane_d      = lane_q;
        bdata_d     = bdata_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d = req_addr_in[ADDR_W+1:2];
`ifdef MAU_BYTE_EN
                    write_d = req_write_in;
                    byte_d  = req_byte_in;
                    lane_d  = req_addr_in[1:0];
                    bdata_d = req_wdata_in[7:0];
                    if (req_write_in && !req_byte_in) begin
`else
                    if (req_write_in) begin
`endif
                        mem_we_d   = 1'b1;
                        mem_data_d = req_wdata_in;
                        state_d    = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: state_d = ST_RDW;
            ST_RDW: begin
`ifdef MAU_BYTE_EN
                if (write_q) begin
                    mem_we_d   = 1'b1;
                    mem_data_d = merged_word;
                    state_d    = ST_WR;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = byte_q ? lane_word : mem_data_in;
                    state_d     = ST_RESP;
                end
`else
                rsp_valid_d = 1'b1;
                rsp_rdata_d = mem_data_in;
                state_d     = ST_RESP;
`endif
            end
            ST_WR: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef MAU_BYTE_EN
            write_q     <= 1'b0;
            byte_q      <= 1'b0;
            lane_q      <= 2'b00;
            bdata_q     <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_we_q    <= mem_we_d;
            mem_data_q  <= mem_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef MAU_BYTE_EN
            write_q     <= write_d;
            byte_q      <= byte_d;
            lane_q      <= lane_d;
            bdata_q     <= bdata_d;
`endif
        end
    end

    assign req_ready_out    = (state_q == ST_IDLE);
    assign rsp_valid_out    = rsp_valid_q;
    assign rsp_rdata_out    = rsp_rdata_q;
    assign mem_write_en_out = mem_we_q;
    assign mem_addr_out     = addr_q;
    assign mem_data_out     = mem_data_q;

endmodule
